// File: rtl/ifetch_line_controller_if.sv
// Fetch-side and memory-side signals of the instruction line controller.
// The master side is the CPU fetch stage plus the instruction memory; the slave side is the controller.
interface ifetch_line_controller_if #(
   parameter int ADDR_W = 16
);
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              flush;
   logic              cpu_valid;
   logic [15:0]       cpu_instr;
   logic              cpu_busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_line;
   logic [15:0]       miss_cnt;

   modport master (
      output cpu_req, cpu_addr, flush, mem_line,
      input  cpu_valid, cpu_instr, cpu_busy, mem_addr, miss_cnt
   );

   modport slave (
      input  cpu_req, cpu_addr, flush, mem_line,
      output cpu_valid, cpu_instr, cpu_busy, mem_addr, miss_cnt
   );
endinterface

// File: rtl/ifetch_line_controller.sv
// One-line instruction buffer: hits answer in one cycle, misses hold the
// memory address for MEM_LATENCY cycles and then capture the 64-bit line.
module ifetch_line_controller #(
   parameter int MEM_LATENCY = 5,
   parameter int ADDR_W      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   ifetch_line_controller_if.slave  bus
);
   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   typedef enum logic {IDLE, FETCH} state_t;

   state_t            state, state_nxt;
   logic [63:0]       line_buf;
   logic [ADDR_W-4:0] tag;
   logic              line_valid;
   logic [3:0]        cnt;
   logic [1:0]        off;
   logic              cpu_valid;
   logic [15:0]       cpu_instr;
   logic [15:0]       miss_cnt;
   logic              hit, accept_hit, accept_miss, capture;

   // Big-endian halfword o of the line: {byte[2o], byte[2o+1]}.
   function automatic logic [15:0] sel(input logic [63:0] line, input logic [1:0] o);
      case (o)
         2'd0:    sel = line[63:48];
         2'd1:    sel = line[47:32];
         2'd2:    sel = line[31:16];
         default: sel = line[15:0];
      endcase
   endfunction

   assign hit = line_valid && (bus.cpu_addr[ADDR_W-1:3] == tag);

   always_comb begin
      state_nxt   = state;
      accept_hit  = 1'b0;
      accept_miss = 1'b0;
      capture     = 1'b0;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.cpu_req) begin
               if (hit) begin
                  accept_hit = 1'b1;
               end else begin
                  accept_miss = 1'b1;
                  state_nxt   = FETCH;
               end
            end
            FETCH: if (cnt == LAT) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         line_buf   <= '0;
         tag        <= '0;
         line_valid <= 1'b0;
         cnt        <= '0;
         off        <= '0;
         cpu_valid  <= 1'b0;
         cpu_instr  <= '0;
         miss_cnt   <= '0;
      end else begin
         cpu_valid <= accept_hit | capture;
         if (bus.flush) begin
            // tag (hence mem_addr) and miss_cnt survive a flush on purpose
            line_valid <= 1'b0;
            cnt        <= '0;
         end else if (accept_hit) begin
            cpu_instr <= sel(line_buf, bus.cpu_addr[2:1]);
         end else if (accept_miss) begin
            tag        <= bus.cpu_addr[ADDR_W-1:3];
            off        <= bus.cpu_addr[2:1];
            cnt        <= 4'd1;
            line_valid <= 1'b0;
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
         end else if (capture) begin
            line_buf   <= bus.mem_line;
            line_valid <= 1'b1;
            cpu_instr  <= sel(bus.mem_line, off);
            cnt        <= '0;
         end else if (state == FETCH) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign bus.cpu_valid = cpu_valid;
   assign bus.cpu_instr = cpu_instr;
   assign bus.cpu_busy  = (state == FETCH);
   assign bus.mem_addr  = {tag, 3'b000};
   assign bus.miss_cnt  = miss_cnt;
endmodule

// File: tb/tb_ifetch_line_controller.sv
// Directed bench for ifetch_line_controller: a per-cycle vector table plus
// hand sequences for flush and reset during a fetch.
module tb_ifetch_line_controller;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ifetch_line_controller_if #(.ADDR_W(16)) bus ();

   ifetch_line_controller #(.MEM_LATENCY(5), .ADDR_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory image: 0x10..0x17 = 11 22 .. 88, everything else addr ^ 0xA5.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      if (a >= 16'h0010 && a <= 16'h0017) mem_byte = 8'h11 * (a[7:0] - 8'h0F);
      else                                mem_byte = a[7:0] ^ 8'hA5;
   endfunction

   always_comb begin
      bus.mem_line = '0;
      for (int k = 0; k < 8; k++)
         bus.mem_line[63-8*k -: 8] = mem_byte(bus.mem_addr + 16'(k));
   end

   typedef struct {
      logic        req;
      logic [15:0] addr;
      logic        exp_valid;
      logic [15:0] exp_instr;
      logic        exp_busy;
      logic [15:0] exp_maddr;
      logic [15:0] exp_miss;
   } vec_t;

   vec_t vt[24];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic v, input logic [15:0] i,
                          input logic b, input logic [15:0] ma, input logic [15:0] mc);
      chk({name, ".valid"}, 32'(bus.cpu_valid), 32'(v));
      chk({name, ".instr"}, 32'(bus.cpu_instr), 32'(i));
      chk({name, ".busy"},  32'(bus.cpu_busy),  32'(b));
      chk({name, ".maddr"}, 32'(bus.mem_addr),  32'(ma));
      chk({name, ".miss"},  32'(bus.miss_cnt),  32'(mc));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          req  addr     v  instr     b  maddr     miss
      vt[0]  = '{1'b1, 16'h0014, 0, 16'h0000, 1, 16'h0010, 16'd1};
      vt[1]  = '{1'b0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'd1};
      vt[2]  = '{1'b1, 16'h0100, 0, 16'h0000, 1, 16'h0010, 16'd1};
      vt[3]  = '{1'b0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'd1};
      vt[4]  = '{1'b0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'd1};
      vt[5]  = '{1'b0, 16'h0000, 1, 16'h5566, 0, 16'h0010, 16'd1};
      vt[6]  = '{1'b1, 16'h0010, 1, 16'h1122, 0, 16'h0010, 16'd1};
      vt[7]  = '{1'b1, 16'h0012, 1, 16'h3344, 0, 16'h0010, 16'd1};
      vt[8]  = '{1'b1, 16'h0016, 1, 16'h7788, 0, 16'h0010, 16'd1};
      vt[9]  = '{1'b1, 16'h0011, 1, 16'h1122, 0, 16'h0010, 16'd1};
      vt[10] = '{1'b0, 16'h0000, 0, 16'h1122, 0, 16'h0010, 16'd1};
      vt[11] = '{1'b1, 16'h0018, 0, 16'h1122, 1, 16'h0018, 16'd2};
      for (int r = 12; r < 16; r++)
         vt[r] = '{1'b0, 16'h0000, 0, 16'h1122, 1, 16'h0018, 16'd2};
      vt[16] = '{1'b0, 16'h0000, 1, 16'hBDBC, 0, 16'h0018, 16'd2};
      vt[17] = '{1'b1, 16'h0010, 0, 16'hBDBC, 1, 16'h0010, 16'd3};
      for (int r = 18; r < 22; r++)
         vt[r] = '{1'b0, 16'h0000, 0, 16'hBDBC, 1, 16'h0010, 16'd3};
      vt[22] = '{1'b0, 16'h0000, 1, 16'h1122, 0, 16'h0010, 16'd3};
      vt[23] = '{1'b0, 16'h0000, 0, 16'h1122, 0, 16'h0010, 16'd3};

      reset = 1'b1;
      bus.cpu_req = 1'b0;
      bus.cpu_addr = '0;
      bus.flush = 1'b0;
      step();
      step();
      chk_all("reset", 0, 16'h0000, 0, 16'h0000, 16'd0);
      reset = 1'b0;

      for (int r = 0; r < 24; r++) begin
         bus.cpu_req  = vt[r].req;
         bus.cpu_addr = vt[r].addr;
         step();
         chk_all($sformatf("vec%0d", r), vt[r].exp_valid, vt[r].exp_instr,
                 vt[r].exp_busy, vt[r].exp_maddr, vt[r].exp_miss);
      end

      // flush in the 3rd FETCH cycle discards the fetch
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
      step();
      chk_all("fl_miss", 0, 16'h1122, 1, 16'h0020, 16'd4);
      bus.cpu_req = 1'b0;
      step();
      step();
      bus.flush = 1'b1;
      step();
      chk_all("fl_abort", 0, 16'h1122, 0, 16'h0020, 16'd4);
      bus.flush = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         chk_all($sformatf("fl_quiet%0d", c), 0, 16'h1122, 0, 16'h0020, 16'd4);
      end
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
      step();
      chk_all("fl_remiss", 0, 16'h1122, 1, 16'h0020, 16'd5);
      bus.cpu_req = 1'b0;
      for (int c = 0; c < 4; c++) step();
      step();
      chk_all("fl_fill", 1, 16'h8584, 0, 16'h0020, 16'd5);

      // flush together with a hit-address request: not accepted, line dropped
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0022; bus.flush = 1'b1;
      step();
      chk_all("flreq_drop", 0, 16'h8584, 0, 16'h0020, 16'd5);
      bus.flush = 1'b0;
      step();
      chk_all("flreq_miss", 0, 16'h8584, 1, 16'h0020, 16'd6);
      bus.cpu_req = 1'b0;
      for (int c = 0; c < 4; c++) step();
      step();
      chk_all("flreq_fill", 1, 16'h8786, 0, 16'h0020, 16'd6);

      // reset during a fetch returns everything to reset values
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0030;
      step();
      chk_all("rst_miss", 0, 16'h8786, 1, 16'h0030, 16'd7);
      bus.cpu_req = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      chk_all("rst_mid", 0, 16'h0000, 0, 16'h0000, 16'd0);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk_all($sformatf("rst_quiet%0d", c), 0, 16'h0000, 0, 16'h0000, 16'd0);
      end
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0030;
      step();
      chk_all("rst_cold", 0, 16'h0000, 1, 16'h0030, 16'd1);
      bus.cpu_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
